// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input controller: PS/2 scancodes,
// control-byte and joystick bit positions, and the keyboard latch layout.
package arcade_input_pkg;

    localparam int unsigned JOY_W  = 16;
    localparam int unsigned CTRL_W = 8;

    localparam logic [7:0] SC_START1  = 8'h16;
    localparam logic [7:0] SC_START2  = 8'h1E;
    localparam logic [7:0] SC_COIN1   = 8'h2E;
    localparam logic [7:0] SC_COIN2   = 8'h36;
    localparam logic [7:0] SC_SERVICE = 8'h46;
    localparam logic [7:0] SC_PAUSE   = 8'h4D;
    localparam logic [7:0] SC_UP      = 8'h75;
    localparam logic [7:0] SC_DOWN    = 8'h72;
    localparam logic [7:0] SC_LEFT    = 8'h6B;
    localparam logic [7:0] SC_RIGHT   = 8'h74;
    localparam logic [7:0] SC_FIRE    = 8'h14;

    // Control byte layout: {down, up, right, left, fire, 0, start, coin}
    localparam int unsigned CB_COIN  = 0;
    localparam int unsigned CB_START = 1;
    localparam int unsigned CB_RSVD  = 2;
    localparam int unsigned CB_FIRE  = 3;
    localparam int unsigned CB_LEFT  = 4;
    localparam int unsigned CB_RIGHT = 5;
    localparam int unsigned CB_UP    = 6;
    localparam int unsigned CB_DOWN  = 7;

    localparam int unsigned JB_RIGHT = 0;
    localparam int unsigned JB_LEFT  = 1;
    localparam int unsigned JB_DOWN  = 2;
    localparam int unsigned JB_UP    = 3;
    localparam int unsigned JB_FIRE  = 4;
    localparam int unsigned JB_START = 5;
    localparam int unsigned JB_COIN  = 7;
    localparam int unsigned JB_PAUSE = 8;

    typedef struct packed {
        logic start1;
        logic start2;
        logic coin1;
        logic coin2;
        logic service;
        logic pause;
        logic up;
        logic down;
        logic left;
        logic right;
        logic fire;
    } key_state_t;

endpackage

// File: rtl/input_pulse_stretch.sv
// Turns a rising edge on raw_i into a fixed-length pulse; edges arriving
// while a pulse is running are ignored, so a held input yields one pulse.
module input_pulse_stretch #(
    parameter logic [15:0] PULSE_LEN = 16'd49152
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic pulse_c
);

    logic [15:0] cnt_q, cnt_d;
    logic        raw_q;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end else if (raw_i && !raw_q) begin
            cnt_d = PULSE_LEN;
        end
    end

    // Looks at the next count so the owner's output register shows the pulse one clock after the edge
    assign pulse_c = (cnt_d != 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
            raw_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            raw_q <= raw_i;
        end
    end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Arcade input controller: merges PS/2 keys and joysticks into registered
// per-player control bytes with coin stretching, autofire and a DIP bank.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS    = 2,
    parameter int unsigned DIP_BYTES      = 8,
    parameter logic [7:0]  DIP_INDEX      = 8'd254,
    parameter logic [15:0] COIN_PULSE_LEN = 16'd49152,
    parameter logic [19:0] AUTOFIRE_DIV   = 20'd409600,
    parameter bit          ACTIVE_LOW     = 1'b0
) (
    input  logic                            clk_49m,
    input  logic                            reset,
    input  logic [10:0]                     ps2_key,
    input  logic [JOY_W*NUM_PLAYERS-1:0]    joystick,
    input  logic                            ioctl_wr,
    input  logic [7:0]                      ioctl_index,
    input  logic [24:0]                     ioctl_addr,
    input  logic [7:0]                      ioctl_dout,
    input  logic                            autofire_en,
    output logic [CTRL_W*NUM_PLAYERS-1:0]   player_ctrl,
    output logic [8*DIP_BYTES-1:0]          dip_sw,
    output logic                            service,
    output logic                            pause_btn
);

    localparam int unsigned CTRL_BITS = CTRL_W * NUM_PLAYERS;

    key_state_t             key_q, key_d;
    logic                   toggle_q;
    logic                   key_evt_c;
    logic [19:0]            af_cnt_q;
    logic                   af_phase_q;
    logic [CTRL_BITS-1:0]   ctrl_d, ctrl_q;
    logic                   pause_q;
    logic [NUM_PLAYERS-1:0] joy_pause;
    logic [1:0]             kb_start, kb_coin;
    logic                   unused_key;

    assign key_evt_c  = ps2_key[10] ^ toggle_q;
    assign unused_key = ps2_key[8];

    // Keyboard latches follow the pressed flag of each recognised scancode
    always_comb begin
        key_d = key_q;
        if (key_evt_c) begin
            case (ps2_key[7:0])
                SC_START1:  key_d.start1  = ps2_key[9];
                SC_START2:  key_d.start2  = ps2_key[9];
                SC_COIN1:   key_d.coin1   = ps2_key[9];
                SC_COIN2:   key_d.coin2   = ps2_key[9];
                SC_SERVICE: key_d.service = ps2_key[9];
                SC_PAUSE:   key_d.pause   = ps2_key[9];
                SC_UP:      key_d.up      = ps2_key[9];
                SC_DOWN:    key_d.down    = ps2_key[9];
                SC_LEFT:    key_d.left    = ps2_key[9];
                SC_RIGHT:   key_d.right   = ps2_key[9];
                SC_FIRE:    key_d.fire    = ps2_key[9];
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            key_q    <= '0;
            toggle_q <= 1'b0;
        end else begin
            key_q    <= key_d;
            toggle_q <= ps2_key[10];
        end
    end

    // Shared autofire square wave, half-period AUTOFIRE_DIV clocks
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            af_cnt_q   <= 20'd0;
            af_phase_q <= 1'b0;
        end else if (af_cnt_q == AUTOFIRE_DIV - 20'd1) begin
            af_cnt_q   <= 20'd0;
            af_phase_q <= ~af_phase_q;
        end else begin
            af_cnt_q   <= af_cnt_q + 20'd1;
        end
    end

    assign kb_start = {key_q.start2, key_q.start1};
    assign kb_coin  = {key_q.coin2, key_q.coin1};

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [JOY_W-1:0]  joy;
        logic [CTRL_W-1:0] byte_c;
        logic              start_raw, coin_raw, coin_pulse, fire_raw;
        logic              unused_joy;

        assign joy        = joystick[JOY_W*p +: JOY_W];
        assign fire_raw   = joy[JB_FIRE] | key_q.fire;
        assign unused_joy = ^{joy[15:9], joy[6]};

        if (p < 2) begin : g_kb
            assign start_raw = joy[JB_START] | kb_start[p];
            assign coin_raw  = joy[JB_COIN] | kb_coin[p];
        end else begin : g_nokb
            assign start_raw = joy[JB_START];
            assign coin_raw  = joy[JB_COIN];
        end

        input_pulse_stretch #(
            .PULSE_LEN (COIN_PULSE_LEN)
        ) u_coin (
            .clk     (clk_49m),
            .rst_n   (reset),
            .raw_i   (coin_raw),
            .pulse_c (coin_pulse)
        );

        always_comb begin
            byte_c           = '0;
            byte_c[CB_COIN]  = coin_pulse;
            byte_c[CB_START] = start_raw;
            byte_c[CB_FIRE]  = fire_raw & (af_phase_q | ~autofire_en);
            byte_c[CB_LEFT]  = joy[JB_LEFT]  | key_q.left;
            byte_c[CB_RIGHT] = joy[JB_RIGHT] | key_q.right;
            byte_c[CB_UP]    = joy[JB_UP]    | key_q.up;
            byte_c[CB_DOWN]  = joy[JB_DOWN]  | key_q.down;
        end

        assign ctrl_d[CTRL_W*p +: CTRL_W] = byte_c ^ {CTRL_W{ACTIVE_LOW}};
        assign joy_pause[p]               = joy[JB_PAUSE];
    end

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            ctrl_q  <= {CTRL_BITS{ACTIVE_LOW}};
            pause_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            pause_q <= key_q.pause | (|joy_pause);
        end
    end

    assign player_ctrl = ctrl_q;
    assign pause_btn   = pause_q;
    assign service     = key_q.service;

    // DIP bank has no reset; stored inverted so a zero-initialised array reads FFh
    logic [7:0] dip_inv_q [DIP_BYTES];
    logic       dip_hit_c;

    assign dip_hit_c = ioctl_wr && (ioctl_index == DIP_INDEX)
                       && (ioctl_addr < 25'(DIP_BYTES));

    always_ff @(posedge clk_49m) begin
        for (int unsigned n = 0; n < DIP_BYTES; n++) begin
            if (dip_hit_c && (ioctl_addr[2:0] == 3'(n))) begin
                dip_inv_q[n] <= ~ioctl_dout;
            end
        end
    end

    for (genvar n = 0; n < DIP_BYTES; n++) begin : g_dip
        assign dip_sw[8*n +: 8] = ~dip_inv_q[n];
    end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Scoreboard bench for arcade_input_ctrl: short coin pulse and fast autofire,
// plus a second active-low instance sharing the same stimulus.
`timescale 1ns/1ps
module tb_arcade_input_ctrl;

    logic        clk_49m = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] ps2_key = '0;
    logic [31:0] joystick = '0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_index = '0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        autofire_en = 1'b0;

    logic [15:0] player_ctrl, player_ctrl_al;
    logic [63:0] dip_sw, dip_sw_al;
    logic        service, pause_btn, service_al, pause_btn_al;

    int errors = 0;
    int checks = 0;
    logic ps2_tog = 1'b0;

    logic [15:0] exp_q [$];
    logic [63:0] dip_exp_q [$];

    always #5 clk_49m = ~clk_49m;

    arcade_input_ctrl #(
        .NUM_PLAYERS(2), .DIP_BYTES(8), .DIP_INDEX(8'd254),
        .COIN_PULSE_LEN(16'd4), .AUTOFIRE_DIV(20'd3), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk_49m(clk_49m), .reset(reset), .ps2_key(ps2_key), .joystick(joystick),
        .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .autofire_en(autofire_en),
        .player_ctrl(player_ctrl), .dip_sw(dip_sw), .service(service), .pause_btn(pause_btn)
    );

    arcade_input_ctrl #(
        .NUM_PLAYERS(2), .DIP_BYTES(8), .DIP_INDEX(8'd254),
        .COIN_PULSE_LEN(16'd4), .AUTOFIRE_DIV(20'd3), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk_49m(clk_49m), .reset(reset), .ps2_key(ps2_key), .joystick(joystick),
        .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .autofire_en(autofire_en),
        .player_ctrl(player_ctrl_al), .dip_sw(dip_sw_al), .service(service_al),
        .pause_btn(pause_btn_al)
    );

    task automatic step();
        @(posedge clk_49m);
        #1;
    endtask

    task automatic send_key(input logic pressed, input logic [7:0] code);
        ps2_tog = ~ps2_tog;
        ps2_key = {ps2_tog, pressed, 1'b0, code};
    endtask

    task automatic apply_reset();
        ps2_tog = 1'b0;
        ps2_key = '0;
        #2 reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        checks++; if (player_ctrl !== 16'h0000) begin errors++; $display("FAIL reset_ctrl: got %h want 0000", player_ctrl); end
        checks++; if (player_ctrl_al !== 16'hFFFF) begin errors++; $display("FAIL reset_ctrl_al: got %h want ffff", player_ctrl_al); end
        checks++; if ({service, pause_btn, service_al, pause_btn_al} !== 4'b0000) begin errors++; $display("FAIL reset_svc_pause: got %b want 0000", {service, pause_btn, service_al, pause_btn_al}); end
        repeat (2) step();
        reset = 1'b1;
        step();
        checks++; if (player_ctrl !== 16'h0000) begin errors++; $display("FAIL idle_ctrl: got %h want 0000", player_ctrl); end
    endtask

    task automatic test_key_up();
        localparam int PRESS = 1;
        localparam int REL   = 6;
        logic [15:0] exp;
        for (int i = 0; i < 12; i++) begin
            if (i == PRESS) send_key(1'b1, 8'h75);
            if (i == REL)   send_key(1'b0, 8'h75);
            exp_q.push_back(((i + 1) >= PRESS + 2 && (i + 1) < REL + 2) ? 16'h4040 : 16'h0000);
            step();
            exp = exp_q.pop_front();
            checks++; if (player_ctrl !== exp) begin errors++; $display("FAIL key_up cycle %0d: got %h want %h", i + 1, player_ctrl, exp); end
        end
    endtask

    task automatic test_key_route();
        logic [15:0] exp;
        send_key(1'b1, 8'h1E); exp_q.push_back(16'h0200); repeat (2) step();
        exp = exp_q.pop_front();
        checks++; if (player_ctrl !== exp) begin errors++; $display("FAIL start2_route: got %h want %h", player_ctrl, exp); end
        send_key(1'b1, 8'h6B); exp_q.push_back(16'h1210); repeat (2) step();
        exp = exp_q.pop_front();
        checks++; if (player_ctrl !== exp) begin errors++; $display("FAIL left_route: got %h want %h", player_ctrl, exp); end
        send_key(1'b1, 8'h5A); exp_q.push_back(16'h1210); repeat (2) step();
        exp = exp_q.pop_front();
        checks++; if (player_ctrl !== exp) begin errors++; $display("FAIL unknown_code: got %h want %h", player_ctrl, exp); end
        send_key(1'b1, 8'h46); step();
        checks++; if (service !== 1'b1) begin errors++; $display("FAIL service_press: got %b want 1", service); end
        send_key(1'b0, 8'h46); step();
        send_key(1'b0, 8'h1E); step();
        send_key(1'b0, 8'h6B); exp_q.push_back(16'h0000); repeat (2) step();
        exp = exp_q.pop_front();
        checks++; if ({player_ctrl, service} !== {exp, 1'b0}) begin errors++; $display("FAIL key_release: got %h/%b want %h/0", player_ctrl, service, exp); end
        joystick[24] = 1'b1; step();
        checks++; if (pause_btn !== 1'b1) begin errors++; $display("FAIL joy_pause_p1: got %b want 1", pause_btn); end
        joystick[24] = 1'b0; step();
        send_key(1'b1, 8'h4D); step();
        checks++; if (pause_btn !== 1'b0) begin errors++; $display("FAIL key_pause_early: got %b want 0", pause_btn); end
        step();
        checks++; if (pause_btn !== 1'b1) begin errors++; $display("FAIL key_pause: got %b want 1", pause_btn); end
        send_key(1'b0, 8'h4D); repeat (2) step();
    endtask

    task automatic test_coin();
        logic [15:0] exp;
        for (int i = 0; i < 26; i++) begin
            if (i == 1)  joystick[7] = 1'b1;
            if (i == 21) joystick[7] = 1'b0;
            exp_q.push_back(((i + 1) >= 2 && (i + 1) <= 5) ? 16'h0001 : 16'h0000);
            step();
            exp = exp_q.pop_front();
            checks++; if (player_ctrl !== exp) begin errors++; $display("FAIL coin_pulse cycle %0d: got %h want %h", i + 1, player_ctrl, exp); end
        end
    endtask

    task automatic test_autofire();
        logic        prev, v, exp_fire, released, found;
        logic [15:0] exp;
        autofire_en = 1'b1;
        joystick[4] = 1'b1;
        repeat (2) step();
        prev = player_ctrl[3];
        found = 1'b0;
        v = prev;
        for (int t = 0; t < 10 && !found; t++) begin
            step();
            if (player_ctrl[3] !== prev) begin found = 1'b1; v = player_ctrl[3]; end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL autofire_toggle: no edge within 10 clocks, fire=%b want toggling", prev);
        end else begin
            released = 1'b0;
            for (int k = 1; k <= 18; k++) begin
                exp_fire = released ? 1'b0 : (v ^ (((k / 3) % 2) == 1));
                exp_q.push_back(16'(exp_fire) << 3);
                step();
                exp = exp_q.pop_front();
                checks++; if (player_ctrl !== exp) begin errors++; $display("FAIL autofire k=%0d: got %h want %h", k, player_ctrl, exp); end
                if (!released && k >= 12 && exp_fire && (v ^ ((((k + 1) / 3) % 2) == 1))) begin
                    joystick[4] = 1'b0;
                    released = 1'b1;
                end
            end
        end
        joystick[4] = 1'b0;
        autofire_en = 1'b0;
        step();
    endtask

    task automatic test_dip();
        logic [63:0] model, exp;
        logic [7:0]  ebyte;
        ioctl_index = 8'd254;
        for (int a = 0; a < 8; a++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_dout = 8'hA0 + 8'(a);
            model[8*a +: 8] = 8'hA0 + 8'(a);
            dip_exp_q.push_back({56'd0, 8'hA0 + 8'(a)});
            step();
            exp = dip_exp_q.pop_front();
            ebyte = exp[7:0];
            checks++; if (dip_sw[8*a +: 8] !== ebyte) begin errors++; $display("FAIL dip_write addr %0d: got %h want %h", a, dip_sw[8*a +: 8], ebyte); end
        end
        ioctl_addr = 25'd8; ioctl_dout = 8'h55; dip_exp_q.push_back(model); step();
        ioctl_wr = 1'b0; step();
        exp = dip_exp_q.pop_front();
        checks++; if (dip_sw !== exp) begin errors++; $display("FAIL dip_addr8: got %h want %h", dip_sw, exp); end
        checks++; if (dip_sw_al !== exp) begin errors++; $display("FAIL dip_al: got %h want %h", dip_sw_al, exp); end
        ioctl_wr = 1'b1; ioctl_index = 8'd253; ioctl_addr = 25'd0; ioctl_dout = 8'h00;
        dip_exp_q.push_back(model); step();
        ioctl_wr = 1'b0;
        exp = dip_exp_q.pop_front();
        checks++; if (dip_sw !== exp) begin errors++; $display("FAIL dip_wrong_index: got %h want %h", dip_sw, exp); end
        ioctl_wr = 1'b1; ioctl_index = 8'd254; ioctl_addr = 25'd3; ioctl_dout = 8'h3C;
        send_key(1'b1, 8'h46);
        model[31:24] = 8'h3C;
        dip_exp_q.push_back(model); step();
        ioctl_wr = 1'b0;
        exp = dip_exp_q.pop_front();
        checks++; if ({dip_sw, service} !== {exp, 1'b1}) begin errors++; $display("FAIL dip_with_key: got %h/%b want %h/1", dip_sw, service, exp); end
        dip_exp_q.push_back(model);
        apply_reset();
        exp = dip_exp_q.pop_front();
        checks++; if (dip_sw !== exp) begin errors++; $display("FAIL dip_after_reset: got %h want %h", dip_sw, exp); end
        checks++; if (service !== 1'b0) begin errors++; $display("FAIL service_after_reset: got %b want 0", service); end
    endtask

    task automatic test_active_low();
        logic [15:0] exp;
        step();
        checks++; if (player_ctrl_al !== 16'hFFFF) begin errors++; $display("FAIL al_idle: got %h want ffff", player_ctrl_al); end
        joystick[0] = 1'b1; exp_q.push_back(16'hFFDF); step();
        exp = exp_q.pop_front();
        checks++; if (player_ctrl_al !== exp) begin errors++; $display("FAIL al_right_p0: got %h want %h", player_ctrl_al, exp); end
        joystick[16] = 1'b1; exp_q.push_back(16'hDFDF); step();
        exp = exp_q.pop_front();
        checks++; if (player_ctrl_al !== exp) begin errors++; $display("FAIL al_right_both: got %h want %h", player_ctrl_al, exp); end
        joystick[0] = 1'b0; joystick[16] = 1'b0; exp_q.push_back(16'hFFFF); step();
        exp = exp_q.pop_front();
        checks++; if (player_ctrl_al !== exp) begin errors++; $display("FAIL al_release: got %h want %h", player_ctrl_al, exp); end
    endtask

    task automatic test_reset_mid_coin();
        logic [15:0] exp;
        joystick[7] = 1'b1;
        repeat (2) step();
        checks++; if (player_ctrl !== 16'h0001) begin errors++; $display("FAIL mid_coin_active: got %h want 0001", player_ctrl); end
        #2 reset = 1'b0;
        #1;
        checks++; if (player_ctrl !== 16'h0000) begin errors++; $display("FAIL coin_async_clear: got %h want 0000", player_ctrl); end
        joystick[7] = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(16'h0000);
            step();
            exp = exp_q.pop_front();
            checks++; if (player_ctrl !== exp) begin errors++; $display("FAIL coin_no_retrigger cycle %0d: got %h want %h", i, player_ctrl, exp); end
        end
        joystick[7] = 1'b1; exp_q.push_back(16'h0001); step();
        exp = exp_q.pop_front();
        checks++; if (player_ctrl !== exp) begin errors++; $display("FAIL coin_new_edge: got %h want %h", player_ctrl, exp); end
        joystick[7] = 1'b0;
        repeat (6) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_key_up();
        test_key_route();
        test_coin();
        test_autofire();
        test_dip();
        test_active_low();
        test_reset_mid_coin();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
